// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types and constants for the byte-serial data memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BEATS = 4;
  localparam int BEAT_W     = 2;
  localparam int LANE_W     = 8;

  // Byte lane b of a 32-bit word, little-endian.
  function automatic logic [LANE_W-1:0] lane_sel(input logic [31:0] w,
                                                 input logic [BEAT_W-1:0] b);
    return w[{b, 3'b000} +: LANE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_word_port.sv
// ============================================================================
// Module : dmem_word_port
// Brief  : Sequences 32-bit / 8-bit loads and stores into byte beats on an
//          8-bit memory with active-low write enable and combinational read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_word_port
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [7:0]        mem_w_data,
  input  logic [7:0]        mem_r_data
);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic                write_q, word_q, signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [23:0]         ldbuf_q;
  logic [31:0]         rdata_q;
  logic                w_last_beat;

  assign w_last_beat = (beat_q == (word_q ? BEAT_W'(WORD_BEATS - 1) : '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)   state_d = ST_XFER;
      ST_XFER: if (w_last_beat) state_d = ST_RESP;
      ST_RESP:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wren    = 1'b1;
    mem_address = '0;
    mem_w_data  = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_XFER: begin
        mem_address = addr_q + ADDR_W'(beat_q);
        mem_wren    = ~write_q;
        mem_w_data  = write_q ? lane_sel(wdata_q, beat_q) : 8'h00;
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata = rdata_q;

  // The final beat's byte goes straight from the memory into the result,
  // so only the three lower lanes need buffering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q   <= '0;
      write_q  <= 1'b0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ldbuf_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            word_q   <= req_word;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            beat_q   <= '0;
          end
        end
        ST_XFER: begin
          if (w_last_beat) begin
            beat_q <= '0;
            if (!write_q) begin
              if (word_q)        rdata_q <= {mem_r_data, ldbuf_q};
              else if (signed_q) rdata_q <= {{24{mem_r_data[7]}}, mem_r_data};
              else               rdata_q <= {24'h000000, mem_r_data};
            end
          end else begin
            beat_q <= beat_q + 1'b1;
            if (!write_q) begin
              case (beat_q)
                2'd0:    ldbuf_q[7:0]   <= mem_r_data;
                2'd1:    ldbuf_q[15:8]  <= mem_r_data;
                2'd2:    ldbuf_q[23:16] <= mem_r_data;
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_word_port.sv
// ============================================================================
// Module : tb_dmem_word_port
// Brief  : Directed self-checking bench with a behavioural 256-byte memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_word_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_word = 1'b0;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_address;
  logic        mem_wren;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;
  int          resp_cnt = 0;

  dmem_word_port #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_word(req_word), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // Initial contents: mem[i] = i ^ 0xA5
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

  always @(posedge clk) if (!mem_wren) mem[mem_address] <= mem_w_data;
  assign mem_r_data = mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // No write strobe while idle or responding; count response pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) resp_cnt++;
      if (req_ready || resp_valid) chk("wren_outside_xfer", {31'd0, mem_wren}, 32'd1);
    end
  end

  // Issue one request; returns edges from accept until resp_valid is seen.
  task automatic xact(input logic w, input logic wd, input logic sg,
                      input logic [7:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    req_write = w; req_word = wd; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
  endtask

  int lat;
  int p0, p1, np;
  int cnt_before;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd1);
    chk("rst_addr", {24'd0, mem_address}, 32'h0);
    chk("rst_wdata", {24'd0, mem_w_data}, 32'h0);
    rst = 1'b0;

    // Word store then word load
    xact(1'b1, 1'b1, 1'b0, 8'h84, 32'h00000315, lat);
    chk("wst_latency", lat, 4);
    chk("wst_rdata_held", resp_rdata, 32'h0);
    chk("mem84", {24'd0, mem[8'h84]}, 32'h15);
    chk("mem85", {24'd0, mem[8'h85]}, 32'h03);
    chk("mem86", {24'd0, mem[8'h86]}, 32'h00);
    chk("mem87", {24'd0, mem[8'h87]}, 32'h00);
    xact(1'b0, 1'b1, 1'b0, 8'h84, 32'h0, lat);
    chk("wld_latency", lat, 4);
    chk("wld_rdata", resp_rdata, 32'h00000315);

    // Byte store, signed / unsigned loads
    xact(1'b1, 1'b0, 1'b0, 8'h90, 32'hDEADBE9C, lat);
    chk("bst_latency", lat, 1);
    chk("bst_rdata_held", resp_rdata, 32'h00000315);
    chk("mem90", {24'd0, mem[8'h90]}, 32'h9C);
    chk("mem91_untouched", {24'd0, mem[8'h91]}, 32'h34);
    xact(1'b0, 1'b0, 1'b1, 8'h90, 32'h0, lat);
    chk("bld_s_latency", lat, 1);
    chk("bld_signed", resp_rdata, 32'hFFFFFF9C);
    xact(1'b0, 1'b0, 1'b0, 8'h90, 32'h0, lat);
    chk("bld_unsigned", resp_rdata, 32'h0000009C);

    // Address wrap-around
    xact(1'b1, 1'b1, 1'b0, 8'hFE, 32'hA1B2C3D4, lat);
    chk("memFE", {24'd0, mem[8'hFE]}, 32'hD4);
    chk("memFF", {24'd0, mem[8'hFF]}, 32'hC3);
    chk("mem00", {24'd0, mem[8'h00]}, 32'hB2);
    chk("mem01", {24'd0, mem[8'h01]}, 32'hA1);
    xact(1'b0, 1'b1, 1'b0, 8'hFE, 32'h0, lat);
    chk("wrap_load", resp_rdata, 32'hA1B2C3D4);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_write = 1'b0; req_word = 1'b1; req_signed = 1'b0; req_addr = 8'h84;
    req_valid = 1'b1;
    @(posedge clk); #1;
    p0 = -1; p1 = -1; np = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        if (np == 0) p0 = i; else p1 = i;
        np++;
        chk("b2b_rdata", resp_rdata, 32'h00000315);
      end
      if (i == 5) chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
      if (i == 2) chk("b2b_ready_busy", {31'd0, req_ready}, 32'd0);
      if (i == 10) req_valid = 1'b0;
    end
    chk("b2b_pulses", np, 2);
    chk("b2b_first", p0, 4);
    chk("b2b_second", p1, 10);

    // Reset after beat 1 of a word store
    @(negedge clk);
    cnt_before = resp_cnt;
    req_write = 1'b1; req_word = 1'b1; req_addr = 8'h10; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_wren", {31'd0, mem_wren}, 32'd1);
    chk("arst_addr", {24'd0, mem_address}, 32'h0);
    chk("arst_wdata", {24'd0, mem_w_data}, 32'h0);
    chk("arst_rdata", resp_rdata, 32'h0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_resp", resp_cnt, cnt_before);
    chk("mem10", {24'd0, mem[8'h10]}, 32'h44);
    chk("mem11", {24'd0, mem[8'h11]}, 32'h33);
    chk("mem12_untouched", {24'd0, mem[8'h12]}, 32'hB7);
    chk("mem13_untouched", {24'd0, mem[8'h13]}, 32'hB6);
    xact(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, lat);
    chk("post_rst_load", resp_rdata, 32'hB6B73344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
